// File: rtl/pipelined_param_approx_wallace_mult.sv
// Pipelined WIDTH x WIDTH multiplier. When requested, the low APPROX_COLS columns are OR-reduced.
// Optional macro APPROX_ERR_STATS_EN adds clear_stats/err_acc, a saturating accumulated-error counter.
module pipelined_param_approx_wallace_mult #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx_en,
`ifdef APPROX_ERR_STATS_EN
    input  logic               clear_stats,
    output logic [31:0]        err_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               out_approx
);
    localparam int PW   = 2 * WIDTH;
    localparam int HALF = WIDTH / 2;

    function automatic logic [PW-1:0] approx_mask_f();
        logic [PW-1:0] m;
        m = {PW{1'b0}};
        for (int c = 0; c < PW; c++) begin
            m[c] = (c < APPROX_COLS) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    localparam logic [PW-1:0] APPROX_MASK = approx_mask_f();

    logic [PW-1:0] row_s;
    logic [PW-1:0] col_or_s;
    logic [PW-1:0] sum_lo_s;
    logic [PW-1:0] sum_hi_s;
    logic [PW-1:0] sum_a_s;

    // Partial-product rows: approximate columns are OR-ed (no carries), the rest summed in two halves.
    always_comb begin
        row_s    = {PW{1'b0}};
        col_or_s = {PW{1'b0}};
        sum_lo_s = {PW{1'b0}};
        sum_hi_s = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            row_s = b[i] ? (PW'(a) << i) : {PW{1'b0}};
            if (approx_en) begin
                col_or_s = col_or_s | (row_s & APPROX_MASK);
                row_s    = row_s & ~APPROX_MASK;
            end else begin
                col_or_s = col_or_s;
            end
            if (i < HALF) begin
                sum_lo_s = sum_lo_s + row_s;
            end else begin
                sum_hi_s = sum_hi_s + row_s;
            end
        end
        // Masked rows leave the approximate columns of sum_lo_s at zero.
        sum_a_s = sum_lo_s | col_or_s;
    end

    logic [PIPE_STAGES-1:0] valid_r;
    logic [PIPE_STAGES-1:0] load_s;
    logic [PIPE_STAGES-1:0] vin_s;
    logic                   all_full_s;
    logic                   run_r;
    logic                   accept_s;

    // A stage loads unless it and every stage downstream of it are full and the output is stalled.
    always_comb begin
        load_s     = {PIPE_STAGES{1'b0}};
        all_full_s = 1'b1;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            all_full_s = all_full_s & valid_r[k];
            load_s[k]  = out_ready | ~all_full_s;
        end
    end

    // Valid bit presented to each stage by its upstream neighbour.
    always_comb begin
        vin_s    = {PIPE_STAGES{1'b0}};
        vin_s[0] = accept_s;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            vin_s[k] = valid_r[k-1];
        end
    end

    assign in_ready  = run_r & load_s[0];
    assign accept_s  = in_valid & in_ready;
    assign out_valid = valid_r[PIPE_STAGES-1];

    // Stage occupancy; run_r keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r   <= 1'b0;
            valid_r <= {PIPE_STAGES{1'b0}};
        end else begin
            run_r <= 1'b1;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= vin_s[k];
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    logic [PW-1:0] fin_a_s;
    logic [PW-1:0] fin_b_s;
    logic          fin_ap_s;
`ifdef APPROX_ERR_STATS_EN
    logic [PW-1:0] exact_s;
    logic [PW-1:0] fin_exact_s;
    assign exact_s = PW'(a) * PW'(b);
`endif

    generate
        if (PIPE_STAGES > 1) begin : g_mid
            localparam int NM = PIPE_STAGES - 1;
            logic [PW-1:0] pa_r [NM];
            logic [PW-1:0] pb_r [NM];
            logic          ap_r [NM];
`ifdef APPROX_ERR_STATS_EN
            logic [PW-1:0] ex_r [NM];
`endif
            // Partial-sum stages ahead of the final add; data only moves with a valid beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < NM; k++) begin
                        pa_r[k] <= {PW{1'b0}};
                        pb_r[k] <= {PW{1'b0}};
                        ap_r[k] <= 1'b0;
`ifdef APPROX_ERR_STATS_EN
                        ex_r[k] <= {PW{1'b0}};
`endif
                    end
                end else begin
                    if (load_s[0] & accept_s) begin
                        pa_r[0] <= sum_a_s;
                        pb_r[0] <= sum_hi_s;
                        ap_r[0] <= approx_en;
`ifdef APPROX_ERR_STATS_EN
                        ex_r[0] <= exact_s;
`endif
                    end
                    for (int k = 1; k < NM; k++) begin
                        if (load_s[k] & valid_r[k-1]) begin
                            pa_r[k] <= pa_r[k-1];
                            pb_r[k] <= pb_r[k-1];
                            ap_r[k] <= ap_r[k-1];
`ifdef APPROX_ERR_STATS_EN
                            ex_r[k] <= ex_r[k-1];
`endif
                        end
                    end
                end
            end
            assign fin_a_s  = pa_r[NM-1];
            assign fin_b_s  = pb_r[NM-1];
            assign fin_ap_s = ap_r[NM-1];
`ifdef APPROX_ERR_STATS_EN
            assign fin_exact_s = ex_r[NM-1];
`endif
        end else begin : g_direct
            assign fin_a_s  = sum_a_s;
            assign fin_b_s  = sum_hi_s;
            assign fin_ap_s = approx_en;
`ifdef APPROX_ERR_STATS_EN
            assign fin_exact_s = exact_s;
`endif
        end
    endgenerate

`ifdef APPROX_ERR_STATS_EN
    logic [PW-1:0] exact_r;
`endif

    // Output register; the final carry-propagate add feeds it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product    <= {PW{1'b0}};
            out_approx <= 1'b0;
`ifdef APPROX_ERR_STATS_EN
            exact_r    <= {PW{1'b0}};
`endif
        end else if (load_s[PIPE_STAGES-1] & vin_s[PIPE_STAGES-1]) begin
            product    <= fin_a_s + fin_b_s;
            out_approx <= fin_ap_s;
`ifdef APPROX_ERR_STATS_EN
            exact_r    <= fin_exact_s;
`endif
        end
    end

`ifdef APPROX_ERR_STATS_EN
    logic [PW-1:0] err_s;
    logic [64:0]   err_sum_s;

    // Error of the beat currently on the output, added to the running total.
    always_comb begin
        err_s     = exact_r - product;
        err_sum_s = 65'(err_acc) + 65'(err_s);
    end

    // Saturating error accumulator; clear wins over an add in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc <= 32'd0;
        end else if (clear_stats) begin
            err_acc <= 32'd0;
        end else if (out_valid & out_ready & out_approx) begin
            err_acc <= (err_sum_s > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : err_sum_s[31:0];
        end
    end
`endif
endmodule

// File: doc/pipelined_param_approx_wallace_mult.md
Name: pipelined_param_approx_wallace_mult

Overview:
Parametrised, pipelined successor to the 8-bit approximate Wallace-tree multiplier. Unsigned WIDTH x WIDTH multiply with the lowest APPROX_COLS product columns OR-reduced (approximate) and the remaining columns reduced exactly. Approximation is selectable per transaction. Valid/ready streaming on both sides, with backpressure. Sits between operand sources and accumulators in the approximate-accumulation datapath.

Parameters:
WIDTH, 8, operand width in bits, 2..32.
APPROX_COLS, 4, number of low product columns that use approximate reduction, 0..2*WIDTH-1; 0 means always exact.
PIPE_STAGES, 2, register stages from input to output, 1..4.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  multiplicand, unsigned.
b  in  WIDTH  multiplier, unsigned.
approx_en  in  1  1 = approximate low columns; 0 = exact product.
out_valid  out  1  product beat valid.
out_ready  in  1  downstream accepts the beat.
product  out  2*WIDTH  result.
out_approx  out  1  approx_en echoed with its product.

Behaviour:
- One clock. Reset is asynchronous, active-low. rst_n=0 immediately clears all stage valid bits. While in reset: out_valid=0, in_ready=0, product=0, out_approx=0. in_ready rises on the first clk edge after release.
- Partial products: pp[i][j] = a[j] & b[i], in column i+j.
- Column contribution, approx_en=1: each column c < APPROX_COLS contributes (OR of all its pp bits) << c. These columns generate no carry into column c+1. Columns >= APPROX_COLS are summed exactly. product = sum of all column contributions, truncated to 2*WIDTH bits. No overflow is possible.
- Column contribution, approx_en=0: product = a*b exactly.
- Reduction logic is split across the PIPE_STAGES register boundaries. The partition is implementer's choice. The final carry-propagate add sits before the last register.
- Latency: an accepted beat (in_valid & in_ready at an edge) appears with out_valid=1 exactly PIPE_STAGES cycles later, provided there is no stall. Throughput is 1 beat per cycle.
- Stall rule: stage k loads when it is empty or when stage k+1 loads in the same cycle. The last stage "loads onward" when out_ready=1. Bubbles collapse.
- in_ready = !valid[0] | advance[0]. in_ready is combinational from out_ready through the stage valids.
- While out_valid=1 and out_ready=0: product and out_approx are held stable, and no stage overwrites a valid unaccepted stage.
- Simultaneous accept at input and output in the same cycle is allowed. No beat is lost or duplicated.
- Beats leave in acceptance order. out_approx always matches the beat's own approx_en.
- Reset asserted mid-stream: all in-flight beats are discarded. No out_valid occurs for them after reset release.

Optional Feature:
Macro APPROX_ERR_STATS_EN.
- Defined: adds ports clear_stats (in, 1) and err_acc (out, 32).
  - Per accepted output beat with out_approx=1, err_acc += (exact a*b - product). The exact value is carried through the pipeline alongside product.
  - err_acc saturates at 0xFFFFFFFF.
  - clear_stats=1 zeroes err_acc at the next edge. A clear takes priority over an add in the same cycle.
  - Reset value of err_acc is 0.
- Undefined: no extra ports, no exact-product datapath, behaviour otherwise identical.

Test Plan:
Defaults apply (WIDTH=8, APPROX_COLS=4, PIPE_STAGES=2) unless stated.
- Single beat: a=0xFF, b=0xFF, approx_en=1, out_ready=1 -> product=0xFDDF, out_approx=1, two cycles after accept. Same operands with approx_en=0 -> 0xFE01.
- Single beat: a=3, b=3, approx_en=1 -> product=0x0007. With approx_en=0 -> 0x0009. Also a=0x80, b=0x80 -> 0x4000 in both modes.
- Back-to-back: 16 beats, one per cycle, random operands, out_ready=1 -> 16 outputs on consecutive cycles, in order. Each output matches the column-OR model.
- Backpressure: hold out_ready=0 and offer 3 beats -> 2 are accepted, then in_ready=0 and the output is held stable. Set out_ready=1 -> the 3 results emerge in order, with no loss or duplication.
- Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately. After release, no stale outputs appear and the first new beat has latency 2.
- With APPROX_ERR_STATS_EN: send approx beats 3*3 then 0xFF*0xFF -> err_acc=36. Pulse clear_stats -> err_acc=0. Repeat the sweep with APPROX_COLS=0 -> err_acc stays 0.
